verificador_senhas: RTL and testbench

- Parametrised password-verification engine for the lock's operational path; successor to the fixed single-password check.
- Holds NUM_SENHAS programmable passwords of 4..PW_MAX digits.
- Keeps the last BUF_DIGITS keypad digits. On '*' it scans serially for any stored password appearing as a contiguous window anywhere in the buffer, so random digits before and after the password are tolerated.
- Counts failed attempts and enforces a timed lockout. The operational FSM consumes its result pulse to drive the lock (tranca) and the buzzer (bip).

---
 rtl/verificador_pkg.sv | 45 ++++
 rtl/verificador_senhas_cmp.sv | 30 +++
 rtl/verificador_senhas.sv | 195 +++++++++++++++++++
 tb/tb_verificador_senhas.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/verificador_pkg.sv
// Shared types and helpers for the password verifier.
// Exports: digit_t, key codes, state_t, senha_slot_t, pw_len().
package verificador_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t KEY_STAR = 4'hA;
   localparam digit_t KEY_HASH = 4'hB;
   localparam digit_t KEY_NONE = 4'hF;

   // Storage capacity of a slot; the PW_MAX parameter must not exceed it.
   localparam int PW_CAP = 16;
   localparam int LEN_W  = $clog2(PW_CAP + 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      RESULT,
      LOCKED
   } state_t;

   typedef struct packed {
      digit_t [PW_CAP-1:0] digits;
      logic [LEN_W-1:0]    len;
      logic                en;
   } senha_slot_t;

   // Number of leading digits before the first F nibble.
   function automatic logic [LEN_W-1:0] pw_len(
      input logic [4*PW_CAP-1:0] raw
   );
      logic             stop;
      logic [LEN_W-1:0] n;
      stop = 1'b0;
      n    = '0;
      for (int k = 0; k < PW_CAP; k++) begin
         if (!stop) begin
            if (raw[4*k +: 4] == KEY_NONE) stop = 1'b1;
            else n = n + 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/verificador_senhas_cmp.sv
// senha_window_cmp: checks one password slot against the digit buffer at offset e.
// Ports: slot (password), hist (buffer, nibble 0 newest), e (offset), hit (window matches).
import verificador_pkg::*;

module senha_window_cmp #(
   parameter int BUF_DIGITS = 20,
   parameter int E_W        = 5
) (
   input  senha_slot_t               slot,
   input  logic [4*BUF_DIGITS-1:0]   hist,
   input  logic [E_W-1:0]            e,
   output logic                      hit
);

   int pos;

   // Password digits are never F, so F buffer entries mismatch on their own.
   always_comb begin
      hit = slot.en;
      pos = 0;
      for (int k = 0; k < PW_CAP; k++) begin
         if (k < int'(slot.len)) begin
            pos = int'(e) + int'(slot.len) - 1 - k;
            if (pos >= BUF_DIGITS) hit = 1'b0;
            else if (hist[pos*4 +: 4] != slot.digits[k]) hit = 1'b0;
         end
      end
   end

endmodule

// File: rtl/verificador_senhas.sv
// verificador_senhas: programmable multi-password verifier with attempt lockout.
// Ports: keypad (digit_in/digit_valid), slot write (senha_*), result (match_*), status (busy, tentativas, bloqueado, bip).
import verificador_pkg::*;

module verificador_senhas #(
   parameter int NUM_SENHAS  = 4,
   parameter int PW_MAX      = 8,
   parameter int PW_MIN      = 4,
   parameter int BUF_DIGITS  = 20,
   parameter int MAX_TENT    = 3,
   parameter int LOCK_CYCLES = 100,
   parameter int BIP_CYCLES  = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [3:0]                        digit_in,
   input  logic                              digit_valid,
   input  logic                              senha_wr,
   input  logic [$clog2(NUM_SENHAS)-1:0]     senha_idx,
   input  logic [4*PW_MAX-1:0]               senha_data,
   output logic                              senha_ack,
   output logic                              busy,
   output logic                              match_valid,
   output logic                              match_ok,
   output logic [$clog2(NUM_SENHAS)-1:0]     match_idx,
   output logic [$clog2(MAX_TENT+1)-1:0]     tentativas,
   output logic                              bloqueado,
   output logic                              bip
);

   localparam int IDX_W  = $clog2(NUM_SENHAS);
   localparam int TENT_W = $clog2(MAX_TENT + 1);
   localparam int E_W    = $clog2(BUF_DIGITS - PW_MIN + 1);
   localparam int LCK_W  = $clog2(LOCK_CYCLES + 1);
   localparam int BIP_W  = $clog2(BIP_CYCLES + 1);

   localparam logic [E_W-1:0]    E_LAST   = E_W'(BUF_DIGITS - PW_MIN);
   localparam logic [TENT_W-1:0] TENT_MAX = TENT_W'(MAX_TENT);

   state_t                  state;
   logic [4*BUF_DIGITS-1:0] hist;
   senha_slot_t             slots [NUM_SENHAS];
   logic [E_W-1:0]          e;
   logic                    ok_r;
   logic [IDX_W-1:0]        idx_r;
   logic [LCK_W-1:0]        lock_cnt;
   logic [BIP_W-1:0]        bip_cnt;

   logic [NUM_SENHAS-1:0]   hits;
   logic                    any_hit;
   logic [IDX_W-1:0]        hit_idx;
   logic [4*PW_CAP-1:0]     data_pad;
   logic [LEN_W-1:0]        pad_len;
   logic [TENT_W-1:0]       tent_inc;

   for (genvar s = 0; s < NUM_SENHAS; s++) begin : g_cmp
      senha_window_cmp #(
         .BUF_DIGITS (BUF_DIGITS),
         .E_W        (E_W)
      ) u_cmp (
         .slot (slots[s]),
         .hist (hist),
         .e    (e),
         .hit  (hits[s])
      );
   end

   // Descending scan so the lowest hitting slot is the one kept.
   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int s = NUM_SENHAS - 1; s >= 0; s--) begin
         if (hits[s]) begin
            any_hit = 1'b1;
            hit_idx = IDX_W'(s);
         end
      end
   end

   always_comb begin
      data_pad = '1;
      data_pad[4*PW_MAX-1:0] = senha_data;
      pad_len  = pw_len(data_pad);
      tent_inc = tentativas + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hist        <= '1;
         e           <= '0;
         ok_r        <= 1'b0;
         idx_r       <= '0;
         lock_cnt    <= '0;
         bip_cnt     <= '0;
         senha_ack   <= 1'b0;
         busy        <= 1'b0;
         match_valid <= 1'b0;
         match_ok    <= 1'b0;
         match_idx   <= '0;
         tentativas  <= '0;
         bloqueado   <= 1'b0;
         bip         <= 1'b0;
         for (int i = 0; i < NUM_SENHAS; i++) begin
            slots[i].digits <= '1;
            slots[i].len    <= '0;
            slots[i].en     <= 1'b0;
         end
      end else begin
         senha_ack   <= 1'b0;
         match_valid <= 1'b0;
         match_ok    <= 1'b0;
         match_idx   <= '0;

         if (bip_cnt != '0) bip_cnt <= bip_cnt - 1'b1;
         else bip <= 1'b0;

         unique case (state)
            IDLE: begin
               if (senha_wr) begin
                  slots[senha_idx].digits <= data_pad;
                  slots[senha_idx].len    <= pad_len;
                  slots[senha_idx].en     <= pad_len >= LEN_W'(PW_MIN);
                  senha_ack               <= 1'b1;
               end
               if (digit_valid) begin
                  unique case (1'b1)
                     (digit_in <= 4'd9):
                        hist <= {hist[4*BUF_DIGITS-5:0], digit_in};
                     (digit_in == KEY_HASH):
                        hist <= '1;
                     (digit_in == KEY_STAR): begin
                        // An empty buffer is not an attempt.
                        if (hist[3:0] != KEY_NONE) begin
                           state <= SCAN;
                           e     <= '0;
                           busy  <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            SCAN: begin
               if (any_hit) begin
                  state <= RESULT;
                  ok_r  <= 1'b1;
                  idx_r <= hit_idx;
               end else if (e == E_LAST) begin
                  state <= RESULT;
                  ok_r  <= 1'b0;
                  idx_r <= '0;
               end else begin
                  e <= e + 1'b1;
               end
            end
            RESULT: begin
               match_valid <= 1'b1;
               match_ok    <= ok_r;
               match_idx   <= ok_r ? idx_r : '0;
               hist        <= '1;
               if (ok_r) begin
                  tentativas <= '0;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end else begin
                  tentativas <= tent_inc;
                  bip        <= 1'b1;
                  bip_cnt    <= BIP_W'(BIP_CYCLES - 1);
                  if (tent_inc == TENT_MAX) begin
                     state     <= LOCKED;
                     bloqueado <= 1'b1;
                     lock_cnt  <= LCK_W'(LOCK_CYCLES - 1);
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            LOCKED: begin
               if (lock_cnt == '0) begin
                  state      <= IDLE;
                  bloqueado  <= 1'b0;
                  tentativas <= '0;
                  busy       <= 1'b0;
               end else begin
                  lock_cnt <= lock_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_verificador_senhas.sv
// Directed self-checking bench for verificador_senhas.
// Drives inputs on the falling edge and samples outputs on the falling edge.
module tb_verificador_senhas;

   logic        clk;
   logic        rst;
   logic [3:0]  digit_in;
   logic        digit_valid;
   logic        senha_wr;
   logic [1:0]  senha_idx;
   logic [31:0] senha_data;
   logic        senha_ack;
   logic        busy;
   logic        match_valid;
   logic        match_ok;
   logic [1:0]  match_idx;
   logic [1:0]  tentativas;
   logic        bloqueado;
   logic        bip;

   int errors = 0;
   int checks = 0;
   int n;
   int nb;
   logic saw_mv;
   logic saw_ack;
   string seq;

   verificador_senhas #(
      .NUM_SENHAS  (4),
      .PW_MAX      (8),
      .PW_MIN      (4),
      .BUF_DIGITS  (20),
      .MAX_TENT    (3),
      .LOCK_CYCLES (16),
      .BIP_CYCLES  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .senha_wr    (senha_wr),
      .senha_idx   (senha_idx),
      .senha_data  (senha_data),
      .senha_ack   (senha_ack),
      .busy        (busy),
      .match_valid (match_valid),
      .match_ok    (match_ok),
      .match_idx   (match_idx),
      .tentativas  (tentativas),
      .bloqueado   (bloqueado),
      .bip         (bip)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] code(input byte c);
      if (c == "*") return 4'hA;
      if (c == "#") return 4'hB;
      return 4'(c - "0");
   endfunction

   // One key per cycle; returns at the falling edge after the last key.
   task automatic type_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         digit_in    = code(s[i]);
         digit_valid = 1'b1;
         @(negedge clk);
      end
      digit_valid = 1'b0;
   endtask

   task automatic wait_mv(input int lim, output int cnt);
      cnt = 0;
      while (!match_valid && cnt < lim) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic wr(input logic [1:0] idx, input logic [31:0] d);
      senha_idx  = idx;
      senha_data = d;
      senha_wr   = 1'b1;
      @(negedge clk);
      senha_wr   = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      digit_in    = 4'h0;
      digit_valid = 1'b0;
      senha_wr    = 1'b0;
      senha_idx   = 2'd0;
      senha_data  = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_outs",
            {busy, match_valid, match_ok, match_idx, tentativas,
             bloqueado, bip, senha_ack}, 0);

      wr(2'd0, 32'h8765_4321);
      check("ack_slot0", senha_ack, 1);

      type_str("00000000000012345678*");
      wait_mv(60, n);
      check("t1_latency", n, 2);
      check("t1_ok", match_ok, 1);
      check("t1_idx", match_idx, 0);
      check("t1_tent", tentativas, 0);

      type_str("12345678000000000000*");
      wait_mv(60, n);
      check("t2_latency", n, 14);
      check("t2_ok", match_ok, 1);
      check("t2_idx", match_idx, 0);

      type_str("123456780000000000000*");
      wait_mv(60, n);
      check("t3_latency", n, 18);
      check("t3_ok", match_ok, 0);
      check("t3_idx", match_idx, 0);
      check("t3_tent", tentativas, 1);
      check("t3_busy", busy, 0);
      nb = 0;
      while (bip && nb < 20) begin
         nb++;
         @(negedge clk);
      end
      check("t3_bip_len", nb, 4);

      wr(2'd1, 32'hFFFF_F321);
      check("ack_slot1", senha_ack, 1);
      wr(2'd2, 32'hFFFF_6789);
      check("ack_slot2", senha_ack, 1);

      type_str("59876*");
      wait_mv(60, n);
      check("t4_latency", n, 2);
      check("t4_ok", match_ok, 1);
      check("t4_idx", match_idx, 2);
      check("t4_tent", tentativas, 0);

      type_str("123*");
      wait_mv(60, n);
      check("t4_slot1_ok", match_ok, 0);
      check("t4_slot1_tent", tentativas, 1);

      type_str("9876*");
      wait_mv(60, n);
      check("t5_clear_ok", match_ok, 1);
      check("t5_clear_tent", tentativas, 0);

      type_str("0000*");
      wait_mv(60, n);
      check("t5_f1_tent", tentativas, 1);
      check("t5_f1_blk", bloqueado, 0);
      type_str("0000*");
      wait_mv(60, n);
      check("t5_f2_tent", tentativas, 2);
      type_str("0000*");
      wait_mv(60, n);
      check("t5_f3_ok", match_ok, 0);
      check("t5_f3_tent", tentativas, 3);
      check("t5_f3_blk", bloqueado, 1);
      check("t5_f3_busy", busy, 1);

      seq     = "12345678*";
      n       = 0;
      saw_mv  = 1'b0;
      saw_ack = 1'b0;
      while (bloqueado && n < 200) begin
         n++;
         digit_valid = 1'b0;
         senha_wr    = 1'b0;
         if (n <= 9) begin
            digit_in    = code(seq[n-1]);
            digit_valid = 1'b1;
         end else if (n == 10) begin
            senha_idx  = 2'd3;
            senha_data = 32'hFFFF_0000;
            senha_wr   = 1'b1;
         end
         @(negedge clk);
         if (match_valid) saw_mv = 1'b1;
         if (senha_ack) saw_ack = 1'b1;
      end
      digit_valid = 1'b0;
      senha_wr    = 1'b0;
      check("lock_len", n, 16);
      check("lock_no_mv", saw_mv, 0);
      check("lock_no_ack", saw_ack, 0);
      check("unlock_tent", tentativas, 0);
      check("unlock_busy", busy, 0);

      type_str("0000*");
      wait_mv(60, n);
      check("slot3_unwritten_ok", match_ok, 0);
      type_str("12345678*");
      wait_mv(60, n);
      check("unlock_ok", match_ok, 1);
      check("unlock_idx", match_idx, 0);
      check("unlock_tent2", tentativas, 0);

      type_str("12345678#*");
      wait_mv(30, n);
      check("hash_no_mv", n, 30);
      check("hash_busy", busy, 0);

      type_str("0*");
      repeat (3) @(negedge clk);
      check("scan_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_outs",
            {busy, match_valid, match_ok, match_idx, tentativas,
             bloqueado, bip, senha_ack}, 0);
      type_str("12345678*");
      wait_mv(60, n);
      check("rst_slots_lat", n, 18);
      check("rst_slots_ok", match_ok, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
